// File: rtl/delta_seq_pkg.sv
// Shared definitions for the time-multiplexed backprop delta engine: FSM encoding,
// fixed-point constants and the run latency.
package delta_seq_pkg;

  localparam int unsigned DefNHlP  = 3;
  localparam int unsigned DefNOut  = 2;
  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefFrac  = 24;

  localparam logic [DefWidth-1:0] FxpOne = 32'(1) << DefFrac;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StOut,
    StHid,
    StDone
  } state_e;

  // Edges from start acceptance until the DONE cycle.
  function automatic int unsigned latency(input int unsigned n_out, input int unsigned n_hl_p);
    return 1 + 3 * n_out + n_hl_p * (n_out + 2);
  endfunction

endpackage

// File: rtl/delta_seq_if.sv
// Start/done handshake plus flattened operand and result buses of delta_seq.
interface delta_seq_if
  import delta_seq_pkg::*;
#(
  parameter int unsigned N_HL_P = DefNHlP,
  parameter int unsigned N_OUT  = DefNOut,
  parameter int unsigned WIDTH  = DefWidth
);

  logic                              i_start;
  logic [N_HL_P*WIDTH-1:0]           i_hd_a;
  logic [N_OUT*N_HL_P*WIDTH-1:0]     i_out_w;
  logic [N_OUT*WIDTH-1:0]            i_out_a;
  logic [N_OUT*WIDTH-1:0]            i_t;
  logic                              o_busy;
  logic                              o_done;
  logic [N_OUT*WIDTH-1:0]            o_cost;
  logic [N_OUT*WIDTH-1:0]            o_dlto;
  logic [N_HL_P*WIDTH-1:0]           o_dlth;

  modport master (
    output i_start, i_hd_a, i_out_w, i_out_a, i_t,
    input  o_busy, o_done, o_cost, o_dlto, o_dlth
  );

  modport slave (
    input  i_start, i_hd_a, i_out_w, i_out_a, i_t,
    output o_busy, o_done, o_cost, o_dlto, o_dlth
  );

endinterface

// File: rtl/delta_seq_fxp_mul.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift by FRAC, truncate.
module fxp_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] p_half_o
);

  logic signed [2*WIDTH-1:0] full;
  logic                      unused_full;

  assign full = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});

  // Slicing the full product is the shift-then-truncate; p_half_o serves the cost term.
  assign p_o      = full[FRAC +: WIDTH];
  assign p_half_o = full[FRAC+1 +: WIDTH];

  assign unused_full = ^{full[FRAC-1:0], full[2*WIDTH-1:FRAC+WIDTH+1]};

endmodule

// File: rtl/delta_seq.sv
// Backprop delta engine: output costs/deltas then hidden deltas, all through one multiplier.
module delta_seq
  import delta_seq_pkg::*;
#(
  parameter int unsigned N_HL_P = DefNHlP,
  parameter int unsigned N_OUT  = DefNOut,
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned FRAC   = DefFrac
) (
  input  logic        clk,
  input  logic        rst,
  delta_seq_if.slave  bus
);

  localparam int unsigned KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned JW = (N_HL_P > 1) ? $clog2(N_HL_P) : 1;
  localparam int unsigned SW = $clog2(N_OUT + 2);

  localparam logic [WIDTH-1:0] One      = WIDTH'(1) << FRAC;
  localparam logic [KW-1:0]    KLast    = KW'(N_OUT - 1);
  localparam logic [JW-1:0]    JLast    = JW'(N_HL_P - 1);
  localparam logic [SW-1:0]    StepAa   = SW'(N_OUT);
  localparam logic [SW-1:0]    StepLast = SW'(N_OUT + 1);

  state_e state_q, state_d;

  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [SW-1:0] step_q;

  logic [WIDTH-1:0] a_hd_q  [N_HL_P];
  logic [WIDTH-1:0] w_q     [N_OUT][N_HL_P];
  logic [WIDTH-1:0] a_out_q [N_OUT];
  logic [WIDTH-1:0] t_q     [N_OUT];
  logic [WIDTH-1:0] err_q   [N_OUT];

  logic [WIDTH-1:0] tmp_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] cost_q  [N_OUT];
  logic [WIDTH-1:0] dlto_q  [N_OUT];
  logic [WIDTH-1:0] dlth_q  [N_HL_P];

  logic [WIDTH-1:0] mul_a, mul_b, mul_p, mul_p_half;

  fxp_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .a_i      (mul_a),
    .b_i      (mul_b),
    .p_o      (mul_p),
    .p_half_o (mul_p_half)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.i_start) state_d = StLoad;
      StLoad: state_d = StOut;
      StOut:  if (step_q == SW'(2) && k_q == KLast) state_d = StHid;
      StHid:  if (step_q == StepLast && j_q == JLast) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.o_busy = 1'b0;
    bus.o_done = 1'b0;
    unique case (state_q)
      StLoad, StOut, StHid: bus.o_busy = 1'b1;
      StDone:               bus.o_done = 1'b1;
      default: ;
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StOut: begin
        if (step_q == SW'(0)) begin
          mul_a = err_q[k_q];
          mul_b = err_q[k_q];
        end else if (step_q == SW'(1)) begin
          mul_a = a_out_q[k_q];
          mul_b = One - a_out_q[k_q];
        end else begin
          mul_a = err_q[k_q];
          mul_b = tmp_q;
        end
      end
      StHid: begin
        if (step_q < StepAa) begin
          mul_a = w_q[step_q[KW-1:0]][j_q];
          mul_b = dlto_q[step_q[KW-1:0]];
        end else if (step_q == StepAa) begin
          mul_a = a_hd_q[j_q];
          mul_b = One - a_hd_q[j_q];
        end else begin
          mul_a = acc_q;
          mul_b = tmp_q;
        end
      end
      default: ;
    endcase
  end

  // Operand capture at start acceptance; errors formed in LOAD
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.i_start) begin
      for (int unsigned kk = 0; kk < N_OUT; kk++) begin
        a_out_q[kk] <= bus.i_out_a[kk*WIDTH +: WIDTH];
        t_q[kk]     <= bus.i_t[kk*WIDTH +: WIDTH];
        for (int unsigned jj = 0; jj < N_HL_P; jj++) begin
          w_q[kk][jj] <= bus.i_out_w[(kk*N_HL_P+jj)*WIDTH +: WIDTH];
        end
      end
      for (int unsigned jj = 0; jj < N_HL_P; jj++) begin
        a_hd_q[jj] <= bus.i_hd_a[jj*WIDTH +: WIDTH];
      end
    end
    if (state_q == StLoad) begin
      for (int unsigned kk = 0; kk < N_OUT; kk++) begin
        err_q[kk] <= a_out_q[kk] - t_q[kk];
      end
    end
  end

  // Counters, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      j_q    <= '0;
      step_q <= '0;
      tmp_q  <= '0;
      acc_q  <= '0;
      for (int unsigned kk = 0; kk < N_OUT; kk++) begin
        cost_q[kk] <= '0;
        dlto_q[kk] <= '0;
      end
      for (int unsigned jj = 0; jj < N_HL_P; jj++) begin
        dlth_q[jj] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle, StLoad, StDone: begin
          k_q    <= '0;
          j_q    <= '0;
          step_q <= '0;
          acc_q  <= '0;
        end
        StOut: begin
          if (step_q == SW'(0)) begin
            cost_q[k_q] <= mul_p_half;
            step_q      <= step_q + SW'(1);
          end else if (step_q == SW'(1)) begin
            tmp_q  <= mul_p;
            step_q <= step_q + SW'(1);
          end else begin
            dlto_q[k_q] <= mul_p;
            step_q      <= '0;
            k_q         <= (k_q == KLast) ? '0 : k_q + KW'(1);
          end
        end
        StHid: begin
          if (step_q < StepAa) begin
            acc_q  <= acc_q + mul_p;
            step_q <= step_q + SW'(1);
          end else if (step_q == StepAa) begin
            tmp_q  <= mul_p;
            step_q <= step_q + SW'(1);
          end else begin
            dlth_q[j_q] <= mul_p;
            acc_q       <= '0;
            step_q      <= '0;
            j_q         <= (j_q == JLast) ? '0 : j_q + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gk = 0; gk < N_OUT; gk++) begin : g_out
    assign bus.o_cost[gk*WIDTH +: WIDTH] = cost_q[gk];
    assign bus.o_dlto[gk*WIDTH +: WIDTH] = dlto_q[gk];
  end

  for (genvar gj = 0; gj < N_HL_P; gj++) begin : g_hid
    assign bus.o_dlth[gj*WIDTH +: WIDTH] = dlth_q[gj];
  end

endmodule

// File: tb/tb_delta_seq.sv
// Directed bench for delta_seq: timing, arithmetic, weight indexing, handshake and reset.
module tb_delta_seq;
  import delta_seq_pkg::*;

  localparam int unsigned NH = 3;
  localparam int unsigned NO = 2;
  localparam int unsigned W  = 32;
  localparam int          L  = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  delta_seq_if #(.N_HL_P(NH), .N_OUT(NO), .WIDTH(W)) bus ();

  delta_seq #(.N_HL_P(NH), .N_OUT(NO), .WIDTH(W), .FRAC(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uniform(input logic [W-1:0] aout, input logic [W-1:0] t,
                             input logic [W-1:0] ahd, input logic [W-1:0] w);
    for (int k = 0; k < NO; k++) begin
      bus.i_out_a[k*W +: W] = aout;
      bus.i_t[k*W +: W]     = t;
    end
    for (int j = 0; j < NH; j++) bus.i_hd_a[j*W +: W] = ahd;
    for (int i = 0; i < NO*NH; i++) bus.i_out_w[i*W +: W] = w;
  endtask

  // Leaves the bench in the cycle after the accepting edge (LOAD).
  task automatic start_run();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (bus.o_done !== 1'b1 && cycles < 60) begin
      if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    set_uniform('0, '0, '0, '0);
    repeat (3) tick();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy);
    end
    checks++;
    if (bus.o_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", bus.o_done);
    end
    checks++;
    if (bus.o_cost !== '0 || bus.o_dlto !== '0 || bus.o_dlth !== '0) begin
      errors++;
      $display("FAIL reset_results got cost %h dlto %h dlth %h want 0",
               bus.o_cost, bus.o_dlto, bus.o_dlth);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc; bit bok;
    set_uniform(32'h0080_0000, FxpOne, 32'h0080_0000, FxpOne);
    start_run();
    wait_done(cyc, bok);
    checks++;
    if (cyc != L) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, L); end
    checks++;
    if (!bok) begin errors++; $display("FAIL basic_busy got low-before-done want high"); end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_at_done got %b want 0", bus.o_busy);
    end
    for (int k = 0; k < NO; k++) begin
      checks++;
      if (bus.o_cost[k*W +: W] !== 32'h0020_0000) begin
        errors++; $display("FAIL basic_cost[%0d] got %h want 00200000", k, bus.o_cost[k*W +: W]);
      end
      checks++;
      if (bus.o_dlto[k*W +: W] !== 32'hFFE0_0000) begin
        errors++; $display("FAIL basic_dlto[%0d] got %h want ffe00000", k, bus.o_dlto[k*W +: W]);
      end
    end
    for (int j = 0; j < NH; j++) begin
      checks++;
      if (bus.o_dlth[j*W +: W] !== 32'hFFF0_0000) begin
        errors++; $display("FAIL basic_dlth[%0d] got %h want fff00000", j, bus.o_dlth[j*W +: W]);
      end
    end
    tick();
    checks++;
    if (bus.o_done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got %b want 0", bus.o_done);
    end
  endtask

  task automatic test_zero_error();
    int cyc; bit bok;
    set_uniform(32'h00C0_0000, 32'h00C0_0000, 32'h0080_0000, FxpOne);
    start_run();
    wait_done(cyc, bok);
    checks++;
    if (cyc != L) begin errors++; $display("FAIL zero_latency got %0d want %0d", cyc, L); end
    checks++;
    if (bus.o_cost !== '0 || bus.o_dlto !== '0 || bus.o_dlth !== '0) begin
      errors++;
      $display("FAIL zero_results got cost %h dlto %h dlth %h want 0",
               bus.o_cost, bus.o_dlto, bus.o_dlth);
    end
    tick();
  endtask

  task automatic test_handshake();
    int ndone = 0;
    int done_at = -1;
    bit busy_bad = 1'b0;
    set_uniform(32'h0080_0000, FxpOne, 32'h0080_0000, FxpOne);
    start_run();
    for (int c = 0; c <= 30; c++) begin
      if (bus.o_done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end else if (done_at < 0 && bus.o_busy !== 1'b1) begin
        busy_bad = 1'b1;
      end
      if (c == 5) begin
        bus.i_start = 1'b1;
        set_uniform(32'h00C0_0000, 32'h00C0_0000, 32'h0000_0000, 32'h0000_0000);
      end
      if (c == 6) bus.i_start = 1'b0;
      tick();
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL hs_done_count got %0d want 1", ndone); end
    checks++;
    if (done_at != L) begin errors++; $display("FAIL hs_latency got %0d want %0d", done_at, L); end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL hs_busy got low-mid-run want high"); end
    for (int k = 0; k < NO; k++) begin
      checks++;
      if (bus.o_dlto[k*W +: W] !== 32'hFFE0_0000) begin
        errors++; $display("FAIL hs_dlto[%0d] got %h want ffe00000", k, bus.o_dlto[k*W +: W]);
      end
    end
    for (int j = 0; j < NH; j++) begin
      checks++;
      if (bus.o_dlth[j*W +: W] !== 32'hFFF0_0000) begin
        errors++; $display("FAIL hs_dlth[%0d] got %h want fff00000", j, bus.o_dlth[j*W +: W]);
      end
    end
  endtask

  task automatic test_weight_index();
    int cyc; bit bok;
    logic [W-1:0] want;
    set_uniform(32'h0080_0000, FxpOne, 32'h0080_0000, 32'h0000_0000);
    bus.i_out_w[(1*NH+2)*W +: W] = FxpOne;
    start_run();
    wait_done(cyc, bok);
    for (int j = 0; j < NH; j++) begin
      want = (j == 2) ? 32'hFFF8_0000 : 32'h0000_0000;
      checks++;
      if (bus.o_dlth[j*W +: W] !== want) begin
        errors++; $display("FAIL widx_dlth[%0d] got %h want %h", j, bus.o_dlth[j*W +: W], want);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit bok;
    int ndone = 0;
    set_uniform(32'h0080_0000, FxpOne, 32'h0080_0000, FxpOne);
    start_run();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got busy %b done %b want 0 0", bus.o_busy, bus.o_done);
    end
    checks++;
    if (bus.o_cost !== '0 || bus.o_dlto !== '0 || bus.o_dlth !== '0) begin
      errors++;
      $display("FAIL rst_mid_results got cost %h dlto %h dlth %h want 0",
               bus.o_cost, bus.o_dlto, bus.o_dlth);
    end
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (bus.o_done === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", ndone); end
    start_run();
    wait_done(cyc, bok);
    checks++;
    if (cyc != L) begin errors++; $display("FAIL rst_rerun_latency got %0d want %0d", cyc, L); end
    checks++;
    if (bus.o_dlth[0 +: W] !== 32'hFFF0_0000 || bus.o_cost[0 +: W] !== 32'h0020_0000) begin
      errors++;
      $display("FAIL rst_rerun_results got dlth0 %h cost0 %h want fff00000 00200000",
               bus.o_dlth[0 +: W], bus.o_cost[0 +: W]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cnt; int lows; int guard;
    set_uniform(32'h0080_0000, FxpOne, 32'h0080_0000, FxpOne);
    bus.i_start = 1'b1;
    guard = 0;
    while (bus.o_done !== 1'b1 && guard < 60) begin tick(); guard++; end
    checks++;
    if (guard >= 60) begin errors++; $display("FAIL b2b_first_done got timeout want pulse"); end
    for (int p = 0; p < 2; p++) begin
      cnt = 0; lows = 0;
      do begin
        tick();
        cnt++;
        if (bus.o_busy !== 1'b1) lows++;
      end while (bus.o_done !== 1'b1 && cnt < 60);
      checks++;
      if (cnt != L + 2) begin
        errors++; $display("FAIL b2b_period[%0d] got %0d want %0d", p, cnt, L + 2);
      end
      checks++;
      if (lows != 2) begin errors++; $display("FAIL b2b_busy_low[%0d] got %0d want 2", p, lows); end
    end
    bus.i_start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL b2b_stop got busy %b done %b want 0 0", bus.o_busy, bus.o_done);
    end
    checks++;
    if (bus.o_dlto[W +: W] !== 32'hFFE0_0000) begin
      errors++; $display("FAIL b2b_dlto1 got %h want ffe00000", bus.o_dlto[W +: W]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0;
    test_reset();
    test_basic();
    test_zero_error();
    test_handshake();
    test_weight_index();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
